// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: sigma constants, state-word indices, FSM encoding
// and the quarter-round arithmetic used by the block function.
package chacha_pkg;

  localparam logic [31:0] CHACHA_CONST0 = 32'h6170_7865;
  localparam logic [31:0] CHACHA_CONST1 = 32'h3320_646e;
  localparam logic [31:0] CHACHA_CONST2 = 32'h7962_2d32;
  localparam logic [31:0] CHACHA_CONST3 = 32'h6b20_6574;

  localparam int W_KEY0    = 4;
  localparam int W_COUNTER = 12;
  localparam int W_NONCE0  = 13;

  typedef logic [511:0] chacha_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GEN    = 2'd1,
    FF     = 2'd2,
    STREAM = 2'd3
  } fsm_state_t;

  // Word i of a packed state lives at [511-32i -: 32].
  function automatic logic [31:0] get_word(input chacha_state_t s, input int i);
    return s[511-32*i -: 32];
  endfunction

  function automatic chacha_state_t build_state(input logic [255:0] key,
                                                input logic [31:0]  counter,
                                                input logic [95:0]  nonce);
    return {CHACHA_CONST0, CHACHA_CONST1, CHACHA_CONST2, CHACHA_CONST3, key, counter, nonce};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                 input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    // NOTE: blocking assignments here are deliberate; each line consumes the value just computed.
    a = a_in + b_in;  d = rotl(d_in ^ a, 16);
    c = c_in + d;     b = rotl(b_in ^ c, 12);
    a = a + b;        d = rotl(d ^ a, 8);
    c = c + d;        b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

endpackage

// File: rtl/chacha_double_round.sv
// One ChaCha double round: four column quarter rounds followed by four diagonal
// quarter rounds, purely combinational over the 512-bit state.
module chacha_double_round
  import chacha_pkg::*;
(
  input  logic [511:0] state_in,
  output logic [511:0] state_out
);

  logic [31:0] x   [16];
  logic [31:0] col [16];
  logic [31:0] dia [16];

  always_comb begin
    for (int i = 0; i < 16; i++) x[i] = get_word(state_in, i);

    for (int i = 0; i < 4; i++)
      {col[i], col[i+4], col[i+8], col[i+12]} = quarter_round(x[i], x[i+4], x[i+8], x[i+12]);

    // Diagonal i starts at column i and steps one column right per row.
    for (int i = 0; i < 4; i++)
      {dia[i], dia[4+((i+1)&3)], dia[8+((i+2)&3)], dia[12+((i+3)&3)]} =
        quarter_round(col[i], col[4+((i+1)&3)], col[8+((i+2)&3)], col[12+((i+3)&3)]);

    state_out = '0;
    for (int i = 0; i < 16; i++) state_out[511-32*i -: 32] = dia[i];
  end

endmodule

// File: rtl/chacha_stream_xor.sv
// ChaCha20 engine XORing the keystream onto a 32-bit stream (RFC 8439).
// Optional macro CHACHA_CTR_WRAP_ERR_EN: stop with sticky err_ctr_wrap on counter wrap.
module chacha_stream_xor
  import chacha_pkg::*;
#(
  parameter int DOUBLE_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_key,
  input  logic [95:0]  cfg_nonce,
  input  logic [31:0]  cfg_counter,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         busy
`ifdef CHACHA_CTR_WRAP_ERR_EN
  ,
  output logic         err_ctr_wrap
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(DOUBLE_ROUNDS - 1);

  fsm_state_t    state;
  chacha_state_t init_q, work_q, ks_q;
  chacha_state_t dr_out, ks_sum, next_block;
  logic [3:0]    idx, rnd;
  logic [31:0]   ctr_next;
  logic          in_stream, xfer, wrap_stop;

  chacha_double_round u_double_round (
    .state_in  (work_q),
    .state_out (dr_out)
  );

  always_comb begin
    ks_sum = '0;
    for (int i = 0; i < 16; i++)
      ks_sum[511-32*i -: 32] = get_word(work_q, i) + get_word(init_q, i);
  end

  // Next block reuses the latched key and nonce with the counter bumped mod 2^32.
  assign ctr_next   = get_word(init_q, W_COUNTER) + 32'd1;
  assign next_block = build_state(init_q[511-32*W_KEY0 -: 256], ctr_next,
                                  init_q[511-32*W_NONCE0 -: 96]);

  assign in_stream = (state == STREAM);
  assign xfer      = in_stream && s_valid && m_ready;
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign s_ready   = in_stream && m_ready;
  assign m_valid   = in_stream && s_valid;
  assign m_last    = in_stream && s_last;
  assign m_data    = in_stream ? (s_data ^ get_word(ks_q, int'(idx))) : 32'd0;

`ifdef CHACHA_CTR_WRAP_ERR_EN
  assign wrap_stop = (get_word(init_q, W_COUNTER) == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (rst)
      err_ctr_wrap <= 1'b0;
    else if (cfg_valid && cfg_ready)
      err_ctr_wrap <= 1'b0;
    else if (xfer && !s_last && idx == 4'd15 && wrap_stop)
      err_ctr_wrap <= 1'b1;
  end
`else
  assign wrap_stop = 1'b0;
`endif

  // NOTE: non-blocking assignments for all state; every register, including the
  // keystream buffer, is cleared so an aborted session leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      init_q <= '0;
      work_q <= '0;
      ks_q   <= '0;
      idx    <= '0;
      rnd    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            init_q <= build_state(cfg_key, cfg_counter, cfg_nonce);
            work_q <= build_state(cfg_key, cfg_counter, cfg_nonce);
            rnd    <= '0;
            state  <= GEN;
          end
        end
        GEN: begin
          work_q <= dr_out;
          rnd    <= rnd + 4'd1;
          if (rnd == LAST_ROUND) state <= FF;
        end
        FF: begin
          ks_q  <= ks_sum;
          idx   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (xfer) begin
            idx <= idx + 4'd1;
            if (s_last) begin
              state <= IDLE;
            end else if (idx == 4'd15) begin
              if (wrap_stop) begin
                state <= IDLE;
              end else begin
                init_q <= next_block;
                work_q <= next_block;
                rnd    <= '0;
                state  <= GEN;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor using RFC 8439 block and encryption vectors.
// Build with CHACHA_CTR_WRAP_ERR_EN defined to exercise the counter-wrap error path.
`timescale 1ns/1ps
module tb_chacha_stream_xor;

  localparam int DOUBLE_ROUNDS = 10;

  localparam logic [255:0] KEY_A = 256'h03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c;
  localparam logic [95:0]  NONCE_BLK = {32'h0900_0000, 32'h4a00_0000, 32'h0000_0000};
  localparam logic [95:0]  NONCE_ENC = {32'h0000_0000, 32'h4a00_0000, 32'h0000_0000};

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [255:0] cfg_key;
  logic [95:0]  cfg_nonce;
  logic [31:0]  cfg_counter;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
`ifdef CHACHA_CTR_WRAP_ERR_EN
  logic         err_ctr_wrap;
`endif

  int checks   = 0;
  int failures = 0;

  logic [8*114-1:0] pt_v;
  logic [8*114-1:0] ct_v;
  logic [31:0]      blk1 [16];

  always #5 clk = ~clk;

  chacha_stream_xor #(.DOUBLE_ROUNDS(DOUBLE_ROUNDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_key      (cfg_key),
    .cfg_nonce    (cfg_nonce),
    .cfg_counter  (cfg_counter),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy)
`ifdef CHACHA_CTR_WRAP_ERR_EN
    ,
    .err_ctr_wrap (err_ctr_wrap)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Little-endian word w of a byte vector whose byte 0 sits in the MSBs; bytes past 113 read as 0.
  function automatic logic [31:0] vec_word(input logic [8*114-1:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (4*w + b < 114) r[8*b +: 8] = v[8*(113-(4*w+b)) +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] word_mask(input int w);
    return (w == 28) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  // Called at a negedge: drives live stream inputs and checks that IDLE ignores them.
  task automatic check_idle(input string tag, input logic exp_err);
    s_valid = 1'b1; s_data = 32'hdead_beef; s_last = 1'b1; m_ready = 1'b1;
    #1;
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_s_ready"},   32'(s_ready),   32'd0);
    check({tag, "_m_valid"},   32'(m_valid),   32'd0);
    check({tag, "_m_data"},    m_data,         32'd0);
    check({tag, "_m_last"},    32'(m_last),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
`ifdef CHACHA_CTR_WRAP_ERR_EN
    check({tag, "_err"},       32'(err_ctr_wrap), 32'(exp_err));
`else
    if (exp_err) check({tag, "_err_unexpected"}, 32'(busy), 32'd1);
`endif
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic start_session(input logic [255:0] key, input logic [95:0] nonce,
                               input logic [31:0] ctr, input string tag);
    int k;
    @(negedge clk);
    cfg_key = key; cfg_nonce = nonce; cfg_counter = ctr; cfg_valid = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    #1 check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    k = 1;
    #1;
    while (!s_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(DOUBLE_ROUNDS + 2));
  endtask

  task automatic send_word(input logic [31:0] data, input logic last, input logic [31:0] exp,
                           input logic [31:0] mask, input logic chk, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = data; s_last = last; m_ready = 1'b1;
    #1;
    while (!s_ready && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd1);
    check({tag, "_m_last"},  32'(m_last),  32'(last));
    if (chk) check({tag, "_data"}, m_data & mask, exp & mask);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic run_block(input string tag);
    start_session(KEY_A, NONCE_BLK, 32'd1, tag);
    for (int w = 0; w < 16; w++)
      send_word(32'd0, w == 15, blk1[w], 32'hffff_ffff, 1'b1, $sformatf("%s_w%0d", tag, w));
    @(negedge clk);
    check_idle({tag, "_end"}, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int cyc;
    rst = 1'b1; cfg_valid = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_counter = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    pt_v = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    ct_v = 912'h6e2e359a2568f98041ba0728dd0d6981_e97e7aec1d4360c20a27afccfd9fae0b_f91b65c5524733ab8f593dabcd62b357_1639d624e65152ab8f530c359f0861d8_07ca0dbf500d6a6156a38e088a22b65e_52bc514d16ccf806818ce91ab7793736_5af90bbf74a35be6b40b8eedf2785e42_874d;
    blk1 = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
             32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
             32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
             32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle("reset", 1'b0);

    // Block-function vector: zero data exposes the raw keystream words.
    run_block("t1");

    // Encryption vector spanning two blocks, final word partially filled.
    start_session(KEY_A, NONCE_ENC, 32'd1, "t2");
    for (int i = 0; i < 29; i++)
      send_word(vec_word(pt_v, i), i == 28, vec_word(ct_v, i), word_mask(i), 1'b1,
                $sformatf("t2_w%0d", i));
    @(negedge clk);
    check_idle("t2_end", 1'b0);

    // Same encryption under random downstream backpressure.
    start_session(KEY_A, NONCE_ENC, 32'd1, "t3");
    w = 0;
    cyc = 0;
    while (w < 29 && cyc < 3000) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      s_valid = 1'b1; s_data = vec_word(pt_v, w); s_last = (w == 28);
      #1;
      if (m_valid) begin
        check("t3_s_ready_eq_m_ready", 32'(s_ready), 32'(m_ready));
        check($sformatf("t3_w%0d_data", w), m_data & word_mask(w), vec_word(ct_v, w) & word_mask(w));
      end else begin
        check("t3_s_ready_outside_stream", 32'(s_ready), 32'd0);
      end
      if (s_ready) w++;
      cyc++;
    end
    check("t3_words_done", 32'(w), 32'd29);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check_idle("t3_end", 1'b0);

    // Reset in the middle of generation.
    @(negedge clk);
    cfg_key = KEY_A; cfg_nonce = NONCE_BLK; cfg_counter = 32'd1; cfg_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);
    s_valid = 1'b1; m_ready = 1'b1;
    #1;
    check("t4_gen_busy",      32'(busy),      32'd1);
    check("t4_gen_cfg_ready", 32'(cfg_ready), 32'd0);
    check("t4_gen_s_ready",   32'(s_ready),   32'd0);
    check("t4_gen_m_valid",   32'(m_valid),   32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    check_idle("t4_gen_rst", 1'b0);
    run_block("t4a");

    // Reset while word 7 is being presented.
    start_session(KEY_A, NONCE_BLK, 32'd1, "t4b");
    for (int i = 0; i < 7; i++)
      send_word(32'd0, 1'b0, blk1[i], 32'hffff_ffff, 1'b1, $sformatf("t4b_w%0d", i));
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'd0; m_ready = 1'b1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    check_idle("t4_stream_rst", 1'b0);
    run_block("t4b_rerun");

    // Counter wrap from 0xffffffff.
    start_session('0, '0, 32'hffff_ffff, "t5");
    for (int i = 0; i < 16; i++)
      send_word(32'd0, 1'b0, 32'd0, 32'd0, 1'b0, $sformatf("t5_w%0d", i));
`ifdef CHACHA_CTR_WRAP_ERR_EN
    @(negedge clk);
    s_valid = 1'b1; s_data = 32'd0; m_ready = 1'b1;
    #1;
    check("t5_err_set",   32'(err_ctr_wrap), 32'd1);
    check("t5_idle_busy", 32'(busy),         32'd0);
    check("t5_cfg_ready", 32'(cfg_ready),    32'd1);
    check("t5_w17_block", 32'(s_ready),      32'd0);
    repeat (3) begin
      @(negedge clk);
      #1 check("t5_w17_never_accepted", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
`else
    send_word(32'd0, 1'b1, 32'hade0_b876, 32'hffff_ffff, 1'b1, "t5_ctr0_w0");
    @(negedge clk);
    check_idle("t5_end", 1'b0);
`endif

    // s_last on word 15, with cfg_valid held high while busy.
    start_session(KEY_A, NONCE_BLK, 32'd1, "t6");
`ifdef CHACHA_CTR_WRAP_ERR_EN
    check("t6_err_cleared", 32'(err_ctr_wrap), 32'd0);
`endif
    @(negedge clk);
    cfg_valid = 1'b1; cfg_key = ~KEY_A; cfg_counter = 32'd7;
    for (int i = 0; i < 16; i++) begin
      send_word(32'd0, i == 15, blk1[i], 32'hffff_ffff, 1'b1, $sformatf("t6_w%0d", i));
      if (i < 15) check("t6_cfg_blocked", 32'(cfg_ready), 32'd0);
    end
    check("t6_idle_busy",      32'(busy),      32'd0);
    check("t6_idle_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    @(negedge clk);
    check_idle("t6_no_regen", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
